// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and requester-select encoding for the data memory arbiter.
// Optional build macro: DMEM_ARB_PERF_EN (stall counters).
package dmem_arb_pkg;

  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;
  localparam int         MAX_WIN_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_CPU  = 2'b01,
    SEL_HOST = 2'b10
  } sel_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side access bundle: req/payload in, gnt and read return out.
// Optional build macro: DMEM_ARB_PERF_EN (not used here).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_fairness.sv
// Winner select with a saturating cpu win counter that forces a host grant.
// Optional build macro: DMEM_ARB_PERF_EN (not used here).
module dmem_arb_fairness
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WIN = MAX_WIN_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic host_req,
  output sel_t sel
);

  localparam int CW =
    (MAX_WIN < 1) ? 1 : $clog2(MAX_WIN + 1);

  logic [CW-1:0] win_cnt;
  logic          contested;
  logic          force_host;

  assign contested  = cpu_req & host_req;
  assign force_host = (win_cnt == CW'(MAX_WIN));

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      contested:
        sel = force_host ? SEL_HOST : SEL_CPU;
      cpu_req & ~host_req:
        sel = SEL_CPU;
      host_req & ~cpu_req:
        sel = SEL_HOST;
      default:
        sel = SEL_NONE;
    endcase
  end

  // A contested cpu win can only happen below MAX_WIN, so saturation
  // is implied; every other cycle clears the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_cnt <= '0;
    end else if (contested && !force_host) begin
      win_cnt <= win_cnt + 1'b1;
    end else begin
      win_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// cpu/host arbiter for the 256x8 data memory plus the memory-mapped I/O byte.
// Optional build macro: DMEM_ARB_PERF_EN adds per-requester stall counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int              ADDR_W  = 8,
  parameter int              DATA_W  = 8,
  parameter logic [ADDR_W-1:0] IO_ADDR =
    ADDR_W'(IO_ADDR_DEFAULT),
  parameter int              MAX_WIN = MAX_WIN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     host,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       host_stall_cnt,
  output logic [15:0]       cpu_stall_cnt
`endif
);

  sel_t              sel;
  logic              granted;
  logic              is_io;
  logic              rd_go;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  sel_t              rd_owner;
  logic              rd_io;
  logic [DATA_W-1:0] io_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] host_hold;

  dmem_arb_fairness #(
    .MAX_WIN (MAX_WIN)
  ) u_fair (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_req  (cpu.req),
    .host_req (host.req),
    .sel      (sel)
  );

  assign cpu.gnt  = (sel == SEL_CPU);
  assign host.gnt = (sel == SEL_HOST);
  assign granted  = cpu.gnt | host.gnt;

  always_comb begin
    win_we    = cpu.we;
    win_addr  = cpu.addr;
    win_wdata = cpu.wdata;
    if (host.gnt) begin
      win_we    = host.we;
      win_addr  = host.addr;
      win_wdata = host.wdata;
    end
  end

  assign is_io     = (win_addr == IO_ADDR);
  assign rd_go     = granted & ~win_we;
  assign mem_en    = granted & ~is_io;
  assign mem_we    = mem_en & win_we;
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;

  // mem_rdata arrives the cycle after the grant; io_in is
  // captured at the grant edge so both paths line up.
  assign rd_data = rd_io ? io_q : mem_rdata;

  assign cpu.rvalid  = (rd_owner == SEL_CPU);
  assign host.rvalid = (rd_owner == SEL_HOST);
  assign cpu.rdata   =
    cpu.rvalid ? rd_data : cpu_hold;
  assign host.rdata  =
    host.rvalid ? rd_data : host_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_owner  <= SEL_NONE;
      rd_io     <= 1'b0;
      io_q      <= '0;
      cpu_hold  <= '0;
      host_hold <= '0;
      io_out    <= '0;
    end else begin
      rd_owner <= rd_go ? sel : SEL_NONE;
      rd_io    <= is_io;
      io_q     <= io_in;
      if (cpu.rvalid) begin
        cpu_hold <= rd_data;
      end
      if (host.rvalid) begin
        host_hold <= rd_data;
      end
      if (granted && win_we && is_io) begin
        io_out <= win_wdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      host_stall_cnt <= '0;
      cpu_stall_cnt  <= '0;
    end else begin
      if (host.req && !host.gnt &&
          host_stall_cnt != 16'hFFFF) begin
        host_stall_cnt <= host_stall_cnt + 16'd1;
      end
      if (cpu.req && !cpu.gnt &&
          cpu_stall_cnt != 16'hFFFF) begin
        cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 sync RAM.
// Optional build macro: DMEM_ARB_PERF_EN enables the stall counter checks.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] io_in, io_out;
  logic [7:0] mem [256];
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] hs_cnt, cs_cnt;
`endif

  int errors = 0;
  int checks = 0;

  dmem_arbiter_if cpu_if ();
  dmem_arbiter_if host_if ();

  dmem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu       (cpu_if),
    .host      (host_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .io_in     (io_in),
    .io_out    (io_out)
`ifdef DMEM_ARB_PERF_EN
    ,
    .host_stall_cnt (hs_cnt),
    .cpu_stall_cnt  (cs_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic       cr, cw;
    logic [7:0] ca, cd;
    logic       hr, hw;
    logic [7:0] ha, hd;
    logic [7:0] io;
    logic       gc, gh, en, we;
    logic [7:0] addr;
    logic       crv;
    logic [7:0] crd;
    logic       hrv;
    logic [7:0] hrd;
    logic [7:0] iout;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic drv(input logic cr, cw,
                     input logic [7:0] ca, cd,
                     input logic hr, hw,
                     input logic [7:0] ha, hd, io);
    cpu_if.req    = cr;
    cpu_if.we     = cw;
    cpu_if.addr   = ca;
    cpu_if.wdata  = cd;
    host_if.req   = hr;
    host_if.we    = hw;
    host_if.addr  = ha;
    host_if.wdata = hd;
    io_in         = io;
  endtask

  function automatic logic [37:0] outs();
    return {cpu_if.gnt, host_if.gnt, mem_en, mem_we,
            mem_en ? mem_addr : 8'h00,
            cpu_if.rvalid, cpu_if.rdata,
            host_if.rvalid, host_if.rdata, io_out};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] ev;
    int hwait;
    int maxw;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;

    //           cr   cw   ca     cd     hr   hw   ha     hd     io
    //           gc   gh   en   we   addr   crv  crd    hrv  hrd    iout
    vecs[0]  = '{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,8'h00,8'h00};
    vecs[1]  = '{1'b1,1'b0,8'h10,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b1,1'b0,1'b1,1'b0,8'h10,1'b0,8'h00,1'b0,8'h00,8'h00};
    vecs[2]  = '{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,8'hA5,1'b0,8'h00,8'h00};
    vecs[3]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,8'h20,8'h5A,8'h00,
                 1'b0,1'b1,1'b1,1'b1,8'h20,1'b0,8'hA5,1'b0,8'h00,8'h00};
    vecs[4]  = '{1'b1,1'b0,8'h20,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b1,1'b0,1'b1,1'b0,8'h20,1'b0,8'hA5,1'b0,8'h00,8'h00};
    vecs[5]  = '{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,8'h5A,1'b0,8'h00,8'h00};
    vecs[6]  = '{1'b1,1'b0,8'hFF,8'h00,1'b0,1'b0,8'h00,8'h00,8'hF0,
                 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,8'h5A,1'b0,8'h00,8'h00};
    vecs[7]  = '{1'b1,1'b1,8'hFF,8'h3C,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b1,1'b0,1'b0,1'b0,8'h00,1'b1,8'hF0,1'b0,8'h00,8'h00};
    vecs[8]  = '{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'hF0,1'b0,8'h00,8'h3C};
    vecs[9]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'hFF,8'h00,8'h77,
                 1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,8'hF0,1'b0,8'h00,8'h3C};
    vecs[10] = '{1'b1,1'b0,8'h10,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b1,1'b0,1'b1,1'b0,8'h10,1'b0,8'hF0,1'b1,8'h77,8'h3C};
    vecs[11] = '{1'b1,1'b0,8'h20,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b1,1'b0,1'b1,1'b0,8'h20,1'b1,8'hA5,1'b0,8'h77,8'h3C};
    vecs[12] = '{1'b1,1'b1,8'h30,8'h11,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b1,1'b0,1'b1,1'b1,8'h30,1'b1,8'h5A,1'b0,8'h77,8'h3C};
    vecs[13] = '{1'b1,1'b0,8'h10,8'h00,1'b1,1'b0,8'h10,8'h00,8'h00,
                 1'b1,1'b0,1'b1,1'b0,8'h10,1'b0,8'h5A,1'b0,8'h77,8'h3C};
    vecs[14] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h10,8'h00,8'h00,
                 1'b0,1'b1,1'b1,1'b0,8'h10,1'b1,8'hA5,1'b0,8'h77,8'h3C};
    vecs[15] = '{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,8'h00,8'h00,
                 1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,8'hA5,1'b1,8'hA5,8'h3C};

    reset_n = 1'b0;
    drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state",
        {cpu_if.rvalid, host_if.rvalid, cpu_if.rdata,
         host_if.rdata, io_out},
        '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drv(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
          vecs[i].hr, vecs[i].hw, vecs[i].ha, vecs[i].hd,
          vecs[i].io);
      #2;
      ev = {vecs[i].gc, vecs[i].gh, vecs[i].en, vecs[i].we,
            vecs[i].addr, vecs[i].crv, vecs[i].crd,
            vecs[i].hrv, vecs[i].hrd, vecs[i].iout};
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(ev));
      @(negedge clk);
    end

    chk("mem20_host_write", 64'(mem[8'h20]), 64'h5A);
    chk("mem30_cpu_write", 64'(mem[8'h30]), 64'h11);
    chk("memFF_untouched", 64'(mem[8'hFF]), 64'h00);

    // contested stream: C,C,C,C,H repeating
    drv(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 8'h00);
    hwait = 0;
    maxw  = 0;
    for (int i = 0; i < 17; i++) begin
      #2;
      chk($sformatf("fair%0d", i),
          {62'd0, cpu_if.gnt, host_if.gnt},
          (i % 5 == 4) ? 64'd1 : 64'd2);
      if (host_if.gnt) hwait = 0;
      else hwait++;
      if (hwait > maxw) maxw = hwait;
      @(negedge clk);
    end
    chk("host_max_wait", 64'(maxw), 64'd4);

    // win_cnt now non-zero; reset lands on the read grant edge
    drv(1, 0, 8'h10, 8'h00, 1, 0, 8'h02, 8'h00, 8'h00);
    reset_n = 1'b0;
    @(negedge clk);
    drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("rst_no_rvalid",
        {55'd0, cpu_if.rvalid, cpu_if.rdata}, 64'd0);
    chk("rst_io_out", 64'(io_out), 64'h00);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_still_quiet",
        {62'd0, cpu_if.rvalid, host_if.rvalid}, 64'd0);

    drv(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("postrst_fair%0d", i),
          {62'd0, cpu_if.gnt, host_if.gnt},
          (i == 4) ? 64'd1 : 64'd2);
      @(negedge clk);
    end

    drv(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    #2;
    chk("postrst_gnt", {63'd0, cpu_if.gnt}, 64'd1);
    @(negedge clk);
    drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    #2;
    chk("postrst_read",
        {55'd0, cpu_if.rvalid, cpu_if.rdata}, 64'h1A5);
    @(negedge clk);

`ifdef DMEM_ARB_PERF_EN
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(i < 4, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00,
          8'h00);
      @(negedge clk);
    end
    drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00);
    chk("host_stall_cnt", 64'(hs_cnt), 64'd4);
    chk("cpu_stall_cnt", 64'(cs_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 data memory between two requesters: the processor load/store port (cpu) and an external host/loader port (host).
- Host is used for preload, debug and readback.
- Also owns the memory-mapped I/O location: reads return external input data, and writes update the output register.
- Sits between the processor datapath, data memory and top-level I/O pins.

Parameters:
ADDR_W, 8, address width of both request ports and memory
DATA_W, 8, data width
IO_ADDR, 8'hFF, address decoded as I/O instead of memory
MAX_WIN, 4, max consecutive contested cycles cpu may win before host is forced a grant

Ports:
clk  in  1  system clock
reset_n  in  1  reset: synchronous, active-low
cpu_req  in  1  cpu access request, held until granted
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  cpu address
cpu_wdata  in  DATA_W  cpu write data
cpu_gnt  out  1  cpu access accepted this cycle
cpu_rvalid  out  1  cpu read data valid
cpu_rdata  out  DATA_W  cpu read data
host_req  in  1  host access request
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access accepted this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_W  host read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous latency
io_in  in  DATA_W  external data input (read at IO_ADDR)
io_out  out  DATA_W  output register (written at IO_ADDR)

Behaviour:
- All state updates on posedge clk.
- Reset (reset_n=0 at edge) clears io_out=0, rvalid flags=0, rdata=0, win counter=0, and the pending-read owner.
- Reset mid-operation discards any in-flight read; no rvalid is issued after reset.
- Grant logic:
  - gnt is combinational from req plus registered state.
  - At most one gnt per cycle.
  - The request is consumed in the cycle gnt=1.
  - A requester keeps req and payload stable until gnt.
- Arbitration:
  - cpu only requesting: cpu wins. host only: host wins.
  - Both requesting: cpu wins unless win_cnt==MAX_WIN, in which case host wins.
  - win_cnt increments on each contested cpu win and saturates at MAX_WIN.
  - win_cnt clears on any host grant or any uncontested cycle.
- Memory path: granted access to an address != IO_ADDR drives mem_en=1 with we/addr/wdata from the winner that cycle. Otherwise mem_en=0 and mem_we=0.
- Reads:
  - rvalid for the winner is asserted exactly 1 cycle after gnt.
  - rdata is taken from mem_rdata, or from the io_in value sampled at the grant edge for IO_ADDR.
  - Back-to-back reads are allowed: one per cycle, returned in order.
  - rdata holds its value when rvalid=0.
- Writes: no rvalid is issued. A write to IO_ADDR loads io_out at the grant edge and does not touch memory.
- Simultaneous cases:
  - A write grant and the previous read's rvalid can occur in the same cycle; both proceed.
  - Equal addresses from both requesters are serialized by arbitration; there is no merge.

Optional Feature:
DMEM_ARB_PERF_EN
- Defined: adds output ports host_stall_cnt[15:0] and cpu_stall_cnt[15:0].
  - Each counts cycles in which that requester had req=1 and gnt=0.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; arbitration is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - constants IO_ADDR_DEFAULT and MAX_WIN_DEFAULT
  - requester-select encoding: SEL_NONE=2'b00, SEL_CPU=2'b01, SEL_HOST=2'b10
- One natural sub-module: dmem_arb_fairness, which contains the win_cnt saturating counter and the forced-host decision.
- Read-return pipeline and I/O decode stay in the top module.

Test Plan:
- cpu read 0x10 with memory preloaded 0xA5 -> cpu_gnt same cycle, mem_en=1, mem_addr=0x10; next cycle cpu_rvalid=1, cpu_rdata=0xA5; host_rvalid stays 0.
- host write 0x20<=0x5A, then cpu read 0x20 -> memory written; cpu_rdata=0x5A one cycle after cpu grant.
- cpu and host both request continuously, MAX_WIN=4 -> grant pattern C,C,C,C,H repeating; host never waits more than 4 cycles.
- io_in=0xF0, cpu read 0xFF -> mem_en=0; cpu_rdata=0xF0 next cycle. cpu write 0xFF<=0x3C -> io_out=0x3C, memory unchanged.
- cpu read granted, reset_n=0 on the following edge -> no cpu_rvalid; io_out=0, win_cnt=0 after release; first post-reset read behaves normally.
- With DMEM_ARB_PERF_EN, host_req held 10 cycles while cpu wins 4 of them -> host_stall_cnt=4.
